// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one registered-output ROM between NUM_REQ burst requesters.
// Optional ROM_ARB_BOUND_CHK_EN adds bound_err and rejects bursts that run past the ROM end.
//
// state | meaning
// IDLE  | pick next requester round-robin, accept base/len
// ISSUE | one ROM read per cycle, base..base+len
// DRAIN | let the last read return, then back to IDLE
module rom_burst_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ROM_DEPTH  = 256,
   parameter int ADDR_WIDTH = $clog2(ROM_DEPTH),
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   output logic                          rom_csen,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_data,
   output logic [NUM_REQ-1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_last,
   output logic                          busy
`ifdef ROM_ARB_BOUND_CHK_EN
   ,
   output logic                          bound_err
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SEL_W = PTR_W + 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]            state_q;
   logic [PTR_W-1:0]      ptr_q;
   logic [PTR_W-1:0]      owner_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  cnt_q;

   logic [PTR_W-1:0]      win_idx;
   logic                  win_found;
   logic [SEL_W-1:0]      cand;
   logic [PTR_W-1:0]      next_ptr;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_base;
   logic [LEN_WIDTH-1:0]  sel_len;
   logic [NUM_REQ-1:0]    owner_oh;

   // First asserted request at or above the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + SEL_W'(i);
         if (cand >= SEL_W'(NUM_REQ)) begin
            cand = cand - SEL_W'(NUM_REQ);
         end
         if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   assign accept    = (state_q == IDLE) && win_found && !rst;
   assign req_ready = accept ? (ONE_HOT0 << win_idx) : '0;
   assign sel_base  = req_base[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_len   = req_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
   assign next_ptr  = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);
   assign owner_oh  = ONE_HOT0 << owner_q;

   assign rom_csen  = (state_q == ISSUE);
   assign rom_addr  = rom_csen ? addr_q : '0;
   assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
   // ROM output is undefined until its first read, so never pass it through unqualified.
   assign rd_data   = (|rd_valid) ? rom_data : '0;

`ifdef ROM_ARB_BOUND_CHK_EN
   localparam int BW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
   logic [BW-1:0] end_addr;
   logic          out_of_range;
   assign end_addr     = BW'(sel_base) + BW'(sel_len);
   assign out_of_range = (end_addr >= BW'(ROM_DEPTH));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         rd_valid  <= '0;
         rd_last   <= 1'b0;
`ifdef ROM_ARB_BOUND_CHK_EN
         bound_err <= 1'b0;
`endif
      end else begin
         rd_valid  <= rom_csen ? owner_oh : '0;
         rd_last   <= rom_csen && (cnt_q == len_q);
`ifdef ROM_ARB_BOUND_CHK_EN
         bound_err <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (accept) begin
                  owner_q <= win_idx;
                  addr_q  <= sel_base;
                  len_q   <= sel_len;
                  cnt_q   <= '0;
                  ptr_q   <= next_ptr;
`ifdef ROM_ARB_BOUND_CHK_EN
                  if (out_of_range) begin
                     bound_err <= 1'b1;
                  end else begin
                     state_q <= ISSUE;
                  end
`else
                  state_q <= ISSUE;
`endif
               end
            end
            ISSUE: begin
               cnt_q  <= cnt_q + LEN_WIDTH'(1);
               addr_q <= (addr_q == ADDR_WIDTH'(ROM_DEPTH-1)) ? '0 : addr_q + ADDR_WIDTH'(1);
               if (cnt_q == len_q) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Self-checking bench for rom_burst_arbiter: ROM model holds mem[a]=a, returned words scoreboarded.
// Bound-check scenario runs only when ROM_ARB_BOUND_CHK_EN is defined; wrap scenario only when it is not.
module tb_rom_burst_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [15:0] req_base = '0;
   logic [15:0] req_len = '0;
   logic        rom_csen;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [1:0]  rd_valid;
   logic [7:0]  rd_data;
   logic        rd_last;
   logic        busy;
`ifdef ROM_ARB_BOUND_CHK_EN
   logic        bound_err;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [1:0] v;
      logic [7:0] d;
      logic       l;
   } exp_t;
   exp_t sb[$];

   rom_burst_arbiter #(
      .NUM_REQ(2), .ROM_DEPTH(256), .ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_base  (req_base),
      .req_len   (req_len),
      .rom_csen  (rom_csen),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .busy      (busy)
`ifdef ROM_ARB_BOUND_CHK_EN
      ,
      .bound_err (bound_err)
`endif
   );

   always #5 clk = ~clk;

   initial rom_data = 'z;
   always @(posedge clk) if (rom_csen) rom_data <= rom_addr;

   // Returned words are compared on the falling edge against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         checks++;
         if (rd_valid !== 2'b00) begin
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected rd_valid=%b data=%h, none expected", rd_valid, rd_data);
            end else begin
               e = sb.pop_front();
               if (rd_valid !== e.v || rd_data !== e.d || rd_last !== e.l) begin
                  errors++;
                  $display("FAIL rd_beat got v=%b d=%h l=%b exp v=%b d=%h l=%b",
                           rd_valid, rd_data, rd_last, e.v, e.d, e.l);
               end
            end
         end else if (rd_data !== 8'h00 || rd_last !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle got d=%h l=%b exp d=00 l=0", rd_data, rd_last);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [7:0] b0, input logic [7:0] l0,
                          input logic [7:0] b1, input logic [7:0] l1);
      req_base  = {b1, b0};
      req_len   = {l1, l0};
      req_valid = v;
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = '0;
      sb.delete();
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      #2;
      checks++;
      if ({req_ready, rom_csen, rom_addr, rd_valid, rd_last, rd_data, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b cs=%b a=%h v=%b l=%b d=%h busy=%b exp all 0",
                  req_ready, rom_csen, rom_addr, rd_valid, rd_last, rd_data, busy);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle got busy=%b rdy=%b exp 0 00", busy, req_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      set_req(2'b01, 8'h10, 8'd3, 8'h00, 8'd0);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL single_grant got %b exp 01", req_ready);
      end
      for (int k = 0; k < 4; k++) sb.push_back('{v: 2'b01, d: 8'(8'h10 + k), l: (k == 3)});
      tick();
      req_base = 16'h0077;  // latched parameters must not follow the inputs
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rom_csen !== 1'b1 || rom_addr !== 8'(8'h10 + k) || busy !== 1'b1 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_issue beat %0d got cs=%b a=%h busy=%b rdy=%b exp cs=1 a=%h busy=1 rdy=00",
                     k, rom_csen, rom_addr, busy, req_ready, 8'(8'h10 + k));
         end
         tick();
      end
      req_valid = '0;
      #1;
      checks++;
      if (rom_csen !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_drain got cs=%b busy=%b exp cs=0 busy=1", rom_csen, busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL single_done got busy=%b pending=%0d exp busy=0 pending=0", busy, sb.size());
      end
   endtask

   task automatic test_contention();
      logic [1:0] g;
      logic [7:0] a;
      do_reset();
      set_req(2'b11, 8'h20, 8'd0, 8'h40, 8'd0);
      for (int b = 0; b < 4; b++) begin
         g = (b % 2 == 0) ? 2'b01 : 2'b10;
         a = (b % 2 == 0) ? 8'h20 : 8'h40;
         checks++;
         if (req_ready !== g) begin
            errors++;
            $display("FAIL contention_grant burst %0d got %b exp %b", b, req_ready, g);
         end
         sb.push_back('{v: g, d: a, l: 1'b1});
         tick();
         checks++;
         if (rom_csen !== 1'b1 || rom_addr !== a || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL contention_issue burst %0d got cs=%b a=%h rdy=%b exp cs=1 a=%h rdy=00",
                     b, rom_csen, rom_addr, req_ready, a);
         end
         tick();
         checks++;
         if (rom_csen !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL contention_drain burst %0d got cs=%b busy=%b rdy=%b exp 0 1 00",
                     b, rom_csen, busy, req_ready);
         end
         tick();
      end
      req_valid = '0;
      tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL contention_done got pending=%0d busy=%b exp 0 0", sb.size(), busy);
      end
   endtask

`ifndef ROM_ARB_BOUND_CHK_EN
   task automatic test_wrap();
      do_reset();
      set_req(2'b01, 8'hFE, 8'd3, 8'h00, 8'd0);
      for (int k = 0; k < 4; k++) sb.push_back('{v: 2'b01, d: 8'(8'hFE + k), l: (k == 3)});
      tick();
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rom_csen !== 1'b1 || rom_addr !== 8'(8'hFE + k)) begin
            errors++;
            $display("FAIL wrap_addr beat %0d got cs=%b a=%h exp cs=1 a=%h", k, rom_csen, rom_addr, 8'(8'hFE + k));
         end
         tick();
      end
      tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_done got pending=%0d busy=%b exp 0 0", sb.size(), busy);
      end
   endtask
`else
   task automatic test_bound();
      do_reset();
      set_req(2'b01, 8'hFC, 8'd4, 8'h00, 8'd0);
      checks++;
      if (req_ready !== 2'b01 || bound_err !== 1'b0) begin
         errors++;
         $display("FAIL bound_accept got rdy=%b err=%b exp 01 0", req_ready, bound_err);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (bound_err !== 1'b1 || rom_csen !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bound_pulse got err=%b cs=%b busy=%b exp 1 0 0", bound_err, rom_csen, busy);
      end
      tick();
      checks++;
      if (bound_err !== 1'b0 || rom_csen !== 1'b0) begin
         errors++;
         $display("FAIL bound_clear got err=%b cs=%b exp 0 0", bound_err, rom_csen);
      end
      set_req(2'b01, 8'hFC, 8'd3, 8'h00, 8'd0);
      for (int k = 0; k < 4; k++) sb.push_back('{v: 2'b01, d: 8'(8'hFC + k), l: (k == 3)});
      tick();
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rom_csen !== 1'b1 || rom_addr !== 8'(8'hFC + k) || bound_err !== 1'b0) begin
            errors++;
            $display("FAIL bound_stream beat %0d got cs=%b a=%h err=%b exp cs=1 a=%h err=0",
                     k, rom_csen, rom_addr, bound_err, 8'(8'hFC + k));
         end
         tick();
      end
      tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bound_done got pending=%0d busy=%b exp 0 0", sb.size(), busy);
      end
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      set_req(2'b10, 8'h00, 8'd0, 8'h00, 8'd7);
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL rstmid_grant got %b exp 10", req_ready);
      end
      for (int k = 0; k < 3; k++) sb.push_back('{v: 2'b10, d: 8'(k), l: 1'b0});
      tick();
      req_valid = '0;
      repeat (4) tick();
      rst = 1'b1;
      req_valid = 2'b11;
      #1;
      checks++;
      if ({req_ready, rom_csen, rom_addr, rd_valid, rd_last, rd_data, busy} !== '0 || sb.size() != 0) begin
         errors++;
         $display("FAIL rstmid_outputs got rdy=%b cs=%b a=%h v=%b l=%b d=%h busy=%b pending=%0d exp all 0",
                  req_ready, rom_csen, rom_addr, rd_valid, rd_last, rd_data, busy, sb.size());
      end
      sb.delete();
      tick();
      set_req(2'b11, 8'h30, 8'd0, 8'h60, 8'd0);
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rstmid_regrant got %b exp 01", req_ready);
      end
      sb.push_back('{v: 2'b01, d: 8'h30, l: 1'b1});
      tick();
      req_valid = '0;
      checks++;
      if (rom_csen !== 1'b1 || rom_addr !== 8'h30) begin
         errors++;
         $display("FAIL rstmid_issue got cs=%b a=%h exp 1 30", rom_csen, rom_addr);
      end
      tick();
      tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_done got pending=%0d busy=%b exp 0 0", sb.size(), busy);
      end
   endtask

   task automatic test_drop();
      do_reset();
      set_req(2'b01, 8'h50, 8'd0, 8'h00, 8'd0);
      sb.push_back('{v: 2'b01, d: 8'h50, l: 1'b1});
      tick();
      req_valid = '0;
      tick();
      set_req(2'b10, 8'h50, 8'd0, 8'h90, 8'd2);
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
         errors++;
         $display("FAIL drop_drain got rdy=%b busy=%b exp 00 1", req_ready, busy);
      end
      tick();
      req_valid = '0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (req_ready !== 2'b00 || rom_csen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle cycle %0d got rdy=%b cs=%b busy=%b exp 00 0 0",
                     k, req_ready, rom_csen, busy);
         end
         tick();
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drop_pending got %0d exp 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
`ifndef ROM_ARB_BOUND_CHK_EN
      test_wrap();
`else
      test_bound();
`endif
      test_reset_mid();
      test_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Shares one synchronous weight/parameter ROM between NUM_REQ requesters, such as conv/fc layer engines fetching weights.
- ROM interface: chip-select `csen`, address `addr`, and registered read data valid one cycle after `csen`.
- Each requester posts a burst as a base address plus a length. The arbiter grants round-robin, sequences consecutive ROM reads and steers returned words to the owner with valid/last strobes.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ROM_DEPTH, 256, words in the shared ROM
- ADDR_WIDTH, $clog2(ROM_DEPTH), ROM address width
- DATA_WIDTH, 8, ROM word width
- LEN_WIDTH, 8, burst length field width; encodes beats-1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester burst request
- req_ready  out  NUM_REQ  one-hot grant; request accepted when valid&ready
- req_base  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_REQ*LEN_WIDTH  packed beats-1, same packing
- rom_csen  out  1  ROM chip select
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_data  in  DATA_WIDTH  ROM registered output
- rd_valid  out  NUM_REQ  one-hot, owner's data strobe
- rd_data  out  DATA_WIDTH  returned word; 0 when no rd_valid bit set
- rd_last  out  1  final beat of burst, coincident with rd_valid
- busy  out  1  high in ISSUE/DRAIN

Behaviour:
- **Reset values** (async on `rst`, regardless of state):
  - req_ready=0, rom_csen=0, rom_addr=0, rd_valid=0, rd_last=0, rd_data=0, busy=0.
  - State IDLE; round-robin pointer=0.
  - Any in-flight burst is abandoned with no further strobes.
- **States:** IDLE, ISSUE, DRAIN.
- **IDLE:**
  - Winner = first asserted req_valid scanning from pointer upward, modulo NUM_REQ.
  - req_ready is combinational, one-hot on the winner, only in IDLE.
  - On accept at cycle T: latch owner, base, len; beat counter=0; pointer=owner+1 mod NUM_REQ; go to ISSUE.
- **ISSUE:**
  - rom_csen=1 every cycle; rom_addr=base+counter.
  - Address wraps from ROM_DEPTH-1 to 0.
  - The first csen occurs at T+1.
  - After the cycle issuing beat len, go to DRAIN.
- **DRAIN:** one cycle, rom_csen=0; then IDLE.
- **Read return:**
  - rd_valid[owner] is registered, one cycle after each csen cycle.
  - rd_data=rom_data, gated to 0 when rd_valid is 0, so the ROM's high-Z reset value never leaks.
  - rd_last is high with the beat-len data.
- **Timing:**
  - Burst of L=len+1 words: data on T+2..T+L+1; next accept earliest at T+L+2.
  - req_ready never asserts outside IDLE.
- **Request deassertion:** requests deasserted before accept are dropped with no side effects. Latched parameters are immune to input changes after accept.
- **len=0:** single beat; rd_last is set on that beat.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Rotation guarantees each waiting requester is served within NUM_REQ bursts.

Optional Feature:
- Macro: ROM_ARB_BOUND_CHK_EN.
- **Defined:**
  - Adds output `bound_err` (1 bit, reset 0).
  - An accepted request with base+len >= ROM_DEPTH (computed at full width, no truncation) issues no ROM reads.
  - bound_err pulses one cycle at T+1.
  - FSM returns to IDLE at T+1; no rd_valid is asserted; pointer still advances.
- **Not defined:** no port; addresses wrap as above.

Test Plan:
- **Single burst:** NUM_REQ=2; req0 base=0x10 len=3; ROM holds mem[a]=a.
  - rom_addr 0x10..0x13 on T+1..T+4.
  - rd_valid=01 with data 0x10..0x13 on T+2..T+5; rd_last at T+5; busy low at T+6.
- **Contention:** req0 and req1 held continuously, len=0.
  - Grants alternate 0,1,0,1; each burst takes 3 cycles.
  - rd_valid alternates 01/10.
- **Wrap:** base=0xFE len=3 (no macro).
  - rom_addr FE,FF,00,01; data FE,FF,00,01; rd_last on 01.
- **Reset mid-burst:** req1 base=0 len=7; assert rst after the 3rd beat returns.
  - All outputs 0 the same cycle.
  - After release, req0 and req1 both pending: req0 granted first (pointer=0).
- **Request dropped:** req_valid pulsed in a DRAIN cycle then removed.
  - No grant, no csen; busy returns to 0.
- **Bound check (macro):** base=0xFC len=4.
  - bound_err=1 at T+1 only; no csen, no rd_valid.
  - A following base=0xFC len=3 streams 4 words normally.
